sm_imem_loader: RTL and testbench

//  Writer side of the instruction-memory interface that the core reads via imAddr/imData.

---
 rtl/sm_imem_loader_pkg.sv | 28 ++
 rtl/sm_imem_loader.sv | 166 ++++++++++++++++
 tb/tb_sm_imem_loader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader: FSM states,
// the default frame marker and timeout, and a byte-lane insert helper.
package sm_imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loaderState_t;

  localparam logic [7:0]  SYNC_DEFAULT    = 8'hA5;
  localparam int unsigned TIMEOUT_DEFAULT = 1000;

  // Little-endian packing: byte idx lands in bits [8*idx +: 8].
  function automatic logic [31:0] insertByte(input logic [31:0] word,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  b);
    logic [31:0] w;
    w = word;
    w[8*idx +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/sm_imem_loader.sv
// Writer side of the instruction RAM: unpacks a framed byte stream into 32-bit
// words, writes them, and holds the core in reset until a frame checks out.
module sm_imem_loader
  import sm_imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEFAULT,
  parameter bit          RUN_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            inData,
  input  logic                  inValid,
  output logic                  inReady,
  output logic                  imWe,
  output logic [ADDR_WIDTH-1:0] imWAddr,
  output logic [31:0]           imWData,
  output logic                  cpuRstN,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam int          TIMER_W = $clog2(TIMEOUT + 1);

  loaderState_t          state;
  logic [7:0]            lenLo;
  logic [7:0]            csum;
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic [ADDR_WIDTH-1:0] wordLast;
  logic [1:0]            byteIdx;
  logic [31:0]           word;
  logic [TIMER_W-1:0]    timer;

  logic        accept;
  logic        timedState;
  logic [15:0] lenWord;

  assign inReady    = (state != ST_DONE);
  assign accept     = inValid & inReady;
  assign timedState = state inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM};
  assign lenWord    = {inData, lenLo};

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, so a mid-frame rst leaves
      // no stale partial word or index that a later frame could pick up.
      state    <= ST_IDLE;
      lenLo    <= '0;
      csum     <= '0;
      wordIdx  <= '0;
      wordLast <= '0;
      byteIdx  <= '0;
      word     <= '0;
      timer    <= '0;
      imWe     <= 1'b0;
      imWAddr  <= '0;
      imWData  <= '0;
      cpuRstN  <= RUN_ON_RESET;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere; each branch reads the pre-edge csum and
      // word, so the checksum compare in CSUM excludes the CSUM byte itself.
      imWe <= 1'b0;
      done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept && inData == SYNC_BYTE) begin
            state   <= ST_LEN0;
            error   <= 1'b0;
            cpuRstN <= 1'b0;
            busy    <= 1'b1;
            csum    <= '0;
          end
        end

        ST_LEN0: begin
          if (accept) begin
            lenLo <= inData;
            csum  <= csum ^ inData;
            state <= ST_LEN1;
          end
        end

        ST_LEN1: begin
          if (accept) begin
            csum <= csum ^ inData;
            if (32'(lenWord) > DEPTH) begin
              state <= ST_ERR;
            end else if (lenWord == 16'd0) begin
              state <= ST_CSUM;
            end else begin
              state    <= ST_DATA;
              wordIdx  <= '0;
              byteIdx  <= '0;
              wordLast <= ADDR_WIDTH'(lenWord - 16'd1);
            end
          end
        end

        ST_DATA: begin
          if (accept) begin
            csum    <= csum ^ inData;
            word    <= insertByte(word, byteIdx, inData);
            byteIdx <= byteIdx + 2'd1;
            if (byteIdx == 2'd3) begin
              imWe    <= 1'b1;
              imWAddr <= wordIdx;
              imWData <= insertByte(word, byteIdx, inData);
              if (wordIdx == wordLast) begin
                state <= ST_CSUM;
              end else begin
                wordIdx <= wordIdx + 1'b1;
              end
            end
          end
        end

        ST_CSUM: begin
          if (accept) begin
            if (inData == csum) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ERR;
            end
          end
        end

        ST_DONE: begin
          busy    <= 1'b0;
          cpuRstN <= 1'b1;
          state   <= ST_IDLE;
        end

        ST_ERR: begin
          // The core stays in reset: the RAM image may be half-overwritten.
          error <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase

      // Inter-byte watchdog; the case above only moves state on an accepted
      // byte, so an expiry here never collides with another transition.
      if (timedState && !accept) begin
        if (timer == TIMER_W'(TIMEOUT - 1)) begin
          state <= ST_ERR;
          timer <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        timer <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sm_imem_loader.sv
// Self-checking bench for sm_imem_loader: frames are modelled as byte lists and
// the expected RAM writes and outcome are derived from the frame rules directly.
module tb_sm_imem_loader;

  localparam int AW      = 6;
  localparam int DEPTH   = 1 << AW;
  localparam int TIMEOUT = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    inData;
  logic          inValid;
  logic          inReady;
  logic          imWe;
  logic [AW-1:0] imWAddr;
  logic [31:0]   imWData;
  logic          cpuRstN;
  logic          busy;
  logic          done;
  logic          error;

  sm_imem_loader #(
    .ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT(TIMEOUT), .RUN_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .inData(inData), .inValid(inValid), .inReady(inReady),
    .imWe(imWe), .imWAddr(imWAddr), .imWData(imWData), .cpuRstN(cpuRstN),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        gotWr[$];
  wr_t        expWr[$];
  logic [7:0] frameQ[$];
  logic [31:0] ramModel [DEPTH];
  int  doneCount, readyLowCount, checks, errors;
  bit  sawRstLow, expOk;

  // Observe the write port and status pulses half a cycle after the edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (imWe) begin
        gotWr.push_back('{addr: imWAddr, data: imWData});
        ramModel[imWAddr] = imWData;
      end
      if (done) doneCount++;
      if (!inReady) readyLowCount++;
      if (busy && !cpuRstN) sawRstLow = 1'b1;
    end
  end

  task automatic clearMon();
    gotWr.delete();
    doneCount     = 0;
    readyLowCount = 0;
    sawRstLow     = 1'b0;
  endtask

  // Reference model: what a frame should do, straight from the frame format.
  task automatic modelFrame();
    int n;
    logic [7:0] x;
    expWr.delete();
    n = int'({frameQ[2], frameQ[1]});
    expOk = 1'b0;
    if (n > DEPTH) return;
    x = 8'h00;
    for (int i = 1; i < 3 + 4 * n; i++) x ^= frameQ[i];
    for (int w = 0; w < n; w++)
      expWr.push_back('{addr: AW'(w),
                        data: {frameQ[6+4*w], frameQ[5+4*w], frameQ[4+4*w], frameQ[3+4*w]}});
    expOk = (frameQ.size() == 4 + 4 * n) && (frameQ[3 + 4 * n] == x);
  endtask

  task automatic buildFrame(input int n, input bit corrupt);
    logic [7:0] b, cs;
    frameQ.delete();
    frameQ.push_back(8'hA5);
    frameQ.push_back(n[7:0]);
    frameQ.push_back(n[15:8]);
    cs = n[7:0] ^ n[15:8];
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      frameQ.push_back(b);
      cs ^= b;
    end
    if (corrupt) cs ^= 8'(1 + $urandom_range(254, 0));
    frameQ.push_back(cs);
  endtask

  task automatic sendByte(input logic [7:0] b, input int gapMax);
    int guard;
    if (gapMax > 0) repeat ($urandom_range(gapMax, 0)) @(negedge clk);
    inData  = b;
    inValid = 1'b1;
    guard   = 0;
    while (!inReady && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 10) begin
      checks++; errors++;
      $display("FAIL send_handshake: inReady stuck at %b, wanted 1", inReady);
    end
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic sendFrame(input int gapMax);
    foreach (frameQ[i]) sendByte(frameQ[i], gapMax);
  endtask

  task automatic sendNoise(input int count, input int gapMax);
    logic [7:0] b;
    for (int i = 0; i < count; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      sendByte(b, gapMax);
    end
  endtask

  function automatic bit wrMatch();
    if (gotWr.size() != expWr.size()) return 1'b0;
    foreach (gotWr[i]) if (gotWr[i] !== expWr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; inValid = 1'b0; inData = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({inReady, imWe, busy, done, error, cpuRstN} !== 6'b100001) begin errors++;
      $display("FAIL reset_flags: got rdy/we/busy/done/err/rstn=%b want 100001",
               {inReady, imWe, busy, done, error, cpuRstN}); end
    checks++; if (imWAddr !== '0 || imWData !== 32'h0) begin errors++;
      $display("FAIL reset_bus: got addr=%0d data=%h want 0/0", imWAddr, imWData); end
  endtask

  task automatic test_basic_frame();
    frameQ = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
    modelFrame(); clearMon();
    sendFrame(0);
    repeat (6) @(negedge clk);
    checks++; if (!wrMatch() || gotWr.size() != 2 || gotWr[1].data !== 32'hDEADBEEF) begin errors++;
      $display("FAIL basic_writes: got %0d writes, want 2 (0:12345678 1:DEADBEEF)", gotWr.size()); end
    checks++; if (doneCount != 1) begin errors++;
      $display("FAIL basic_done: got %0d done cycles, want 1", doneCount); end
    checks++; if (!sawRstLow || cpuRstN !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin errors++;
      $display("FAIL basic_status: sawLow=%b rstn=%b busy=%b err=%b want 1/1/0/0",
               sawRstLow, cpuRstN, busy, error); end
  endtask

  task automatic test_bad_csum();
    frameQ = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h29};
    modelFrame(); clearMon();
    sendFrame(0);
    repeat (6) @(negedge clk);
    checks++; if (!wrMatch() || ramModel[1] !== 32'hDEADBEEF) begin errors++;
      $display("FAIL badcsum_writes: got %0d writes ram1=%h, want 2 / DEADBEEF", gotWr.size(), ramModel[1]); end
    checks++; if (doneCount != 0 || error !== 1'b1 || cpuRstN !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL badcsum_status: done=%0d err=%b rstn=%b busy=%b want 0/1/0/0",
               doneCount, error, cpuRstN, busy); end
  endtask

  task automatic test_zero_len();
    int doneAt;
    frameQ = '{8'hA5, 8'h00, 8'h00, 8'h00};
    clearMon();
    doneAt = -1;
    sendByte(frameQ[0], 0);
    for (int i = 1; i < 4; i++) sendByte(frameQ[i], 0);
    // The final sendByte returns at the negedge where DONE is showing.
    if (done) doneAt = 0;
    repeat (5) @(negedge clk);
    checks++; if (doneAt != 0 || doneCount != 1) begin errors++;
      $display("FAIL zero_done: at=%0d count=%0d, want 0/1", doneAt, doneCount); end
    checks++; if (gotWr.size() != 0 || error !== 1'b0 || cpuRstN !== 1'b1) begin errors++;
      $display("FAIL zero_status: writes=%0d err=%b rstn=%b want 0/0/1", gotWr.size(), error, cpuRstN); end
  endtask

  task automatic test_max_len();
    frameQ = '{8'hA5, 8'h41, 8'h00};
    clearMon();
    sendFrame(0);
    repeat (4) @(negedge clk);
    checks++; if (error !== 1'b1 || gotWr.size() != 0 || busy !== 1'b0 || cpuRstN !== 1'b0) begin errors++;
      $display("FAIL over_len: err=%b writes=%0d busy=%b rstn=%b want 1/0/0/0",
               error, gotWr.size(), busy, cpuRstN); end
    buildFrame(DEPTH, 1'b0);
    modelFrame(); clearMon();
    sendFrame(0);
    repeat (6) @(negedge clk);
    checks++; if (!wrMatch() || gotWr[DEPTH-1].addr !== AW'(DEPTH - 1)) begin errors++;
      $display("FAIL full_writes: got %0d writes, want %0d ending at %0d", gotWr.size(), DEPTH, DEPTH - 1); end
    checks++; if (ramModel[DEPTH-1] !== expWr[DEPTH-1].data || doneCount != 1) begin errors++;
      $display("FAIL full_done: ram[last]=%h want %h, done=%0d want 1",
               ramModel[DEPTH-1], expWr[DEPTH-1].data, doneCount); end
  endtask

  task automatic test_timeout();
    frameQ = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
    clearMon();
    sendFrame(0);
    repeat (TIMEOUT - 20) @(negedge clk);
    checks++; if (busy !== 1'b1 || error !== 1'b0) begin errors++;
      $display("FAIL timeout_early: busy=%b err=%b want 1/0", busy, error); end
    repeat (40) @(negedge clk);
    checks++; if (error !== 1'b1 || busy !== 1'b0 || cpuRstN !== 1'b0 || gotWr.size() != 0) begin errors++;
      $display("FAIL timeout_abort: err=%b busy=%b rstn=%b writes=%0d want 1/0/0/0",
               error, busy, cpuRstN, gotWr.size()); end
    buildFrame(3, 1'b0);
    modelFrame(); clearMon();
    sendFrame(0);
    repeat (6) @(negedge clk);
    checks++; if (!wrMatch() || error !== 1'b0 || doneCount != 1) begin errors++;
      $display("FAIL timeout_recover: writes=%0d err=%b done=%0d want 3/0/1",
               gotWr.size(), error, doneCount); end
  endtask

  task automatic test_mid_reset();
    buildFrame(2, 1'b0);
    modelFrame(); clearMon();
    for (int i = 0; i < 9; i++) sendByte(frameQ[i], 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (gotWr.size() != 1 || gotWr[0] !== expWr[0]) begin errors++;
      $display("FAIL midrst_writes: got %0d writes, want only word 0", gotWr.size()); end
    checks++; if (cpuRstN !== 1'b1 || busy !== 1'b0 || imWAddr !== '0 || imWData !== 32'h0) begin errors++;
      $display("FAIL midrst_state: rstn=%b busy=%b addr=%0d data=%h want 1/0/0/0",
               cpuRstN, busy, imWAddr, imWData); end
    buildFrame(4, 1'b0);
    modelFrame(); clearMon();
    sendFrame(0);
    repeat (6) @(negedge clk);
    checks++; if (!wrMatch() || doneCount != 1) begin errors++;
      $display("FAIL midrst_reload: writes=%0d done=%0d want 4/1", gotWr.size(), doneCount); end
  endtask

  task automatic test_back_to_back();
    wr_t firstWr[$];
    buildFrame(1, 1'b0);
    modelFrame();
    firstWr = expWr;
    clearMon();
    sendFrame(0);
    buildFrame(2, 1'b0);
    modelFrame();
    expWr = {firstWr, expWr};
    sendFrame(0);
    repeat (6) @(negedge clk);
    checks++; if (!wrMatch() || doneCount != 2) begin errors++;
      $display("FAIL b2b_result: writes=%0d done=%0d want 3/2", gotWr.size(), doneCount); end
    checks++; if (readyLowCount != 2) begin errors++;
      $display("FAIL b2b_ready: inReady low %0d cycles, want 2", readyLowCount); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      if (it == 0) frameQ = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                              8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h28};
      else buildFrame(int'($urandom_range(6, 1)), ($urandom_range(3, 0) == 0));
      modelFrame(); clearMon();
      sendNoise(int'($urandom_range(3, 0)), 20);
      sendFrame(30);
      repeat (6) @(negedge clk);
      checks++; if (!wrMatch()) begin errors++;
        $display("FAIL rand_writes[%0d]: got %0d writes, want %0d", it, gotWr.size(), expWr.size()); end
      checks++; if (doneCount != int'(expOk) || error !== !expOk || cpuRstN !== expOk) begin errors++;
        $display("FAIL rand_status[%0d]: done=%0d err=%b rstn=%b want ok=%b",
                 it, doneCount, error, cpuRstN, expOk); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_frame();
    test_bad_csum();
    test_zero_len();
    test_max_len();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
